pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central sequencer for the 5-stage pipeline's stage-register write enables, flushes and bubble insertion.
- Merges three stall sources: the load-use hazard flag, the ID-stage branch-taken flag, and a multi-cycle data-memory request/acknowledge handshake.
- Gates pipeline start-up and detects hung memory transactions.
- Sits beside the hazard detection unit in the CPU top and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls.

Parameters:
- WAIT_MAX, 255: maximum cycles spent in MEM_WAIT before timeout; the counter width is derived from it as clog2(WAIT_MAX+1).
- CNT_W, 32: width of the performance counters; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  level; allows the pipeline to leave IDLE.
- hazard_i  in  1  load-use hazard detected in ID.
- branch_taken_i  in  1  branch resolved taken in ID.
- dmem_req_i  in  1  MEM stage holds a load or store.
- dmem_ack_i  in  1  data memory has completed the access.
- dmem_start_o  out  1  one-cycle request strobe to data memory.
- pc_write_o  out  1  PC register enable.
- ifid_write_o  out  1  IF/ID enable.
- ifid_flush_o  out  1  zero IF/ID on this edge.
- idex_noop_o  out  1  load NOP control into ID/EX.
- idex_write_o  out  1  ID/EX enable.
- exmem_write_o  out  1  EX/MEM enable.
- memwb_write_o  out  1  MEM/WB enable.
- err_o  out  1  sticky timeout error.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALT. Outputs are combinational from state and inputs; state and counters are registered.
- Reset (rst_i=0, asynchronous):
  - state=IDLE, wait counter=0, err_o=0.
  - All enables 0, and dmem_start_o, ifid_flush_o, idex_noop_o are 0.
  - Reset mid-transaction abandons the access without any handshake.
- IDLE:
  - All enables 0.
  - start_i=1 → RUN on the next edge; no enable is asserted in the same cycle start_i rises.
- RUN, priority memory > load-use > branch:
  - Memory: dmem_req_i=1 → dmem_start_o=1, all five enables 0, counter cleared, next state MEM_WAIT. hazard_i and branch_taken_i are ignored.
  - Load-use: else if hazard_i=1 → pc_write_o=0, ifid_write_o=0, idex_noop_o=1. The idex, exmem and memwb enables stay 1. branch_taken_i is ignored because ID is re-evaluated next cycle.
  - Branch: else if branch_taken_i=1 → all enables 1, ifid_flush_o=1.
  - Otherwise all enables are 1 and the flush/noop outputs are 0.
  - dmem_ack_i is ignored in RUN.
  - start_i falling has no effect once running.
- MEM_WAIT:
  - All enables 0, dmem_start_o=0, counter increments every cycle.
  - dmem_ack_i=1 → in that cycle, all enables 1 and the hazard/branch rules of RUN are applied; next state RUN.
    - The ack has priority over a simultaneous timeout.
    - The ack-cycle advance moves the load or store out of MEM, so no re-issue follows.
  - Counter reaches WAIT_MAX with no ack → next state HALT.
- HALT:
  - All enables 0, err_o=1.
  - Left only via reset.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, adds CNT_W-bit outputs:
  - perf_cycles_o: cycles spent in RUN or MEM_WAIT.
  - perf_memwait_o: cycles in MEM_WAIT, including the start cycle.
  - perf_loaduse_o: cycles with a load-use bubble.
  - perf_flush_o: cycles with ifid_flush_o=1.
- All counters reset to 0, saturate at all-ones, and freeze in HALT.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3);
  - a stage_ctrl struct bundling pc_write, ifid_write, ifid_flush, idex_noop, idex_write, exmem_write, memwb_write;
  - the WAIT_MAX default constant.
- One natural sub-module, pipe_perf_counter: a single saturating CNT_W counter with enable, instantiated four times under the macro.

Test Plan:
- Start-up: reset released, start_i=0 for 3 cycles then 1 → enables 0 through the first edge after start_i, then all 1; err_o=0.
- Load-use: RUN, hazard_i=1 with branch_taken_i=1 for 1 cycle → pc_write_o=0, ifid_write_o=0, idex_noop_o=1, ifid_flush_o=0; next cycle with both inputs 0 → all enables 1.
- Memory: RUN, dmem_req_i=1, ack returned 4 cycles after start → dmem_start_o high exactly 1 cycle, enables 0 for 4 cycles, all 1 on the ack cycle, state RUN after.
- Ack with branch: ack cycle coincides with branch_taken_i=1 → enables 1 and ifid_flush_o=1 in that cycle.
- Timeout: WAIT_MAX=8, no ack → HALT after 8 wait cycles, err_o=1 held; a late ack is ignored; rst_i low then high → IDLE, err_o=0.
- Reset mid-wait: rst_i pulsed low during MEM_WAIT → outputs reset immediately without waiting for a clock edge; with PIPE_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t       : sequencer states (IDLE, RUN, MEM_WAIT, HALT)
//   stage_ctrl_t  : bundle of stage-register controls driven toward the pipeline
//   WAIT_MAX_DEFAULT : default memory-wait timeout in cycles
//   run_ctrl()    : stage controls for a cycle in which the pipeline may advance,
//                   applying the load-use bubble before the branch flush
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_noop;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
    } stage_ctrl_t;

    localparam int WAIT_MAX_DEFAULT = 255;

    // A load-use hazard freezes PC and IF/ID and injects a bubble into ID/EX.
    // The branch flag is ignored then because ID re-evaluates next cycle.
    function automatic stage_ctrl_t run_ctrl(input logic hazard, input logic branch_taken);
        stage_ctrl_t c;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_noop   = 1'b0;
        c.idex_write  = 1'b1;
        c.exmem_write = 1'b1;
        c.memwb_write = 1'b1;
        if (hazard) begin
            c.pc_write   = 1'b0;
            c.ifid_write = 1'b0;
            c.idex_noop  = 1'b1;
        end else if (branch_taken) begin
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake/control bundle between the CPU core and the stall sequencer.
//   Core -> sequencer : start_i, hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i
//   Sequencer -> core : dmem_start_o, pc_write_o, ifid_write_o, ifid_flush_o,
//                       idex_noop_o, idex_write_o, exmem_write_o, memwb_write_o, err_o
// Modports: slave = sequencer side, master = core/environment side.
interface pipeline_stall_ctrl_if;
    logic start_i;
    logic hazard_i;
    logic branch_taken_i;
    logic dmem_req_i;
    logic dmem_ack_i;
    logic dmem_start_o;
    logic pc_write_o;
    logic ifid_write_o;
    logic ifid_flush_o;
    logic idex_noop_o;
    logic idex_write_o;
    logic exmem_write_o;
    logic memwb_write_o;
    logic err_o;

    modport slave (
        input  start_i, hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        output dmem_start_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_noop_o,
               idex_write_o, exmem_write_o, memwb_write_o, err_o
    );

    modport master (
        output start_i, hazard_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        input  dmem_start_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_noop_o,
               idex_write_o, exmem_write_o, memwb_write_o, err_o
    );
endinterface

// File: rtl/pipe_perf_counter.sv
// Saturating event counter.
//   clk_i : clock          rst_i : asynchronous active-low reset (clears to 0)
//   en_i  : count enable   cnt_o : current count, holds at all-ones
module pipe_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk_i, rst_i (async, active-low) : plain scalar ports
//   ctrl_if (slave modport)          : start/hazard/branch/dmem handshake inputs and
//                                      the PC, IF/ID, ID/EX, EX/MEM, MEM/WB controls,
//                                      dmem_start_o strobe and sticky err_o
// Stage controls are combinational from state and inputs; state, the memory-wait
// counter and the error flag are registered.
// Optional build macro PIPE_PERF_CNT_EN adds four saturating CNT_W-bit counters:
// perf_cycles_o, perf_memwait_o, perf_loaduse_o, perf_flush_o.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
`ifdef PIPE_PERF_CNT_EN
    ,parameter int CNT_W   = 32
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipeline_stall_ctrl_if.slave ctrl_if
`ifdef PIPE_PERF_CNT_EN
    ,output logic [CNT_W-1:0]   perf_cycles_o
    ,output logic [CNT_W-1:0]   perf_memwait_o
    ,output logic [CNT_W-1:0]   perf_loaduse_o
    ,output logic [CNT_W-1:0]   perf_flush_o
`endif
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    // The counter is cleared in the request cycle and counts each MEM_WAIT cycle,
    // so seeing WAIT_MAX-1 here means this is the WAIT_MAX-th wait cycle.
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_MAX - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    stage_ctrl_t   ctrl;
    logic          dmem_start;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ctrl       = '0;
        dmem_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_if.start_i) state_d = RUN;
            end
            RUN: begin
                if (ctrl_if.dmem_req_i) begin
                    dmem_start = 1'b1;
                    cnt_d      = '0;
                    state_d    = MEM_WAIT;
                end else begin
                    ctrl = run_ctrl(ctrl_if.hazard_i, ctrl_if.branch_taken_i);
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // Ack wins over a coincident timeout; the advance retires the access.
                if (ctrl_if.dmem_ack_i) begin
                    ctrl    = run_ctrl(ctrl_if.hazard_i, ctrl_if.branch_taken_i);
                    state_d = RUN;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ctrl_if.dmem_start_o  = dmem_start;
    assign ctrl_if.pc_write_o    = ctrl.pc_write;
    assign ctrl_if.ifid_write_o  = ctrl.ifid_write;
    assign ctrl_if.ifid_flush_o  = ctrl.ifid_flush;
    assign ctrl_if.idex_noop_o   = ctrl.idex_noop;
    assign ctrl_if.idex_write_o  = ctrl.idex_write;
    assign ctrl_if.exmem_write_o = ctrl.exmem_write;
    assign ctrl_if.memwb_write_o = ctrl.memwb_write;
    assign ctrl_if.err_o         = err_q;

`ifdef PIPE_PERF_CNT_EN
    logic busy_en, memwait_en;
    assign busy_en    = (state_q == RUN) || (state_q == MEM_WAIT);
    // The request cycle in RUN counts as a memory-wait cycle too.
    assign memwait_en = (state_q == MEM_WAIT) || dmem_start;

    pipe_perf_counter #(.W(CNT_W)) u_cnt_cycles (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(busy_en), .cnt_o(perf_cycles_o)
    );
    pipe_perf_counter #(.W(CNT_W)) u_cnt_memwait (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(memwait_en), .cnt_o(perf_memwait_o)
    );
    pipe_perf_counter #(.W(CNT_W)) u_cnt_loaduse (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(ctrl.idex_noop), .cnt_o(perf_loaduse_o)
    );
    pipe_perf_counter #(.W(CNT_W)) u_cnt_flush (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(ctrl.ifid_flush), .cnt_o(perf_flush_o)
    );
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (WAIT_MAX = 8).
// Observed outputs are packed as {dmem_start, pc_write, ifid_write, ifid_flush,
// idex_noop, idex_write, exmem_write, memwb_write, err}.
module tb_pipeline_stall_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    localparam logic [8:0] O_ZERO  = 9'b0_00_00_000_0;
    localparam logic [8:0] O_ALL   = 9'b0_11_00_111_0;
    localparam logic [8:0] O_LU    = 9'b0_00_01_111_0;
    localparam logic [8:0] O_BR    = 9'b0_11_10_111_0;
    localparam logic [8:0] O_START = 9'b1_00_00_000_0;
    localparam logic [8:0] O_HALT  = 9'b0_00_00_000_1;

    pipeline_stall_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] pc_cyc, pc_mw, pc_lu, pc_fl;
    pipeline_stall_ctrl #(.WAIT_MAX(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .ctrl_if(bus.slave),
        .perf_cycles_o(pc_cyc), .perf_memwait_o(pc_mw),
        .perf_loaduse_o(pc_lu), .perf_flush_o(pc_fl)
    );
`else
    pipeline_stall_ctrl #(.WAIT_MAX(8)) dut (
        .clk_i(clk), .rst_i(rst_n), .ctrl_if(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.dmem_start_o, bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                bus.idex_noop_o, bus.idex_write_o, bus.exmem_write_o, bus.memwb_write_o,
                bus.err_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic hz, input logic br,
                         input logic rq, input logic ak);
        bus.start_i        = st;
        bus.hazard_i       = hz;
        bus.branch_taken_i = br;
        bus.dmem_req_i     = rq;
        bus.dmem_ack_i     = ak;
        #2;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b1;
        bus.start_i = 0; bus.hazard_i = 0; bus.branch_taken_i = 0;
        bus.dmem_req_i = 0; bus.dmem_ack_i = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'(outs()), 32'(O_ZERO));
`ifdef PIPE_PERF_CNT_EN
        chk("reset_perf", pc_cyc | pc_mw | pc_lu | pc_fl, 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;

        // Start-up gating: three idle cycles, then start.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("idle_no_start", 32'(outs()), 32'(O_ZERO));
            step();
        end
        drive(1, 0, 0, 0, 0);
        chk("idle_start_cycle", 32'(outs()), 32'(O_ZERO));
        step();
        drive(1, 0, 0, 0, 0);
        chk("run_first", 32'(outs()), 32'(O_ALL));
        step();
        drive(0, 0, 0, 0, 0);
        chk("run_start_low", 32'(outs()), 32'(O_ALL));
        step();

        // Load-use beats branch.
        drive(0, 1, 1, 0, 0);
        chk("loaduse_over_branch", 32'(outs()), 32'(O_LU));
        step();
        drive(0, 0, 0, 0, 0);
        chk("after_loaduse", 32'(outs()), 32'(O_ALL));
        step();
        drive(0, 0, 1, 0, 1);
        chk("branch_flush", 32'(outs()), 32'(O_BR));
        step();

        // Memory access: ack four cycles after the start strobe.
        drive(0, 1, 1, 1, 0);
        chk("mem_start", 32'(outs()), 32'(O_START));
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("mem_wait", 32'(outs()), 32'(O_ZERO));
            step();
        end
        drive(0, 0, 0, 1, 1);
        chk("mem_ack", 32'(outs()), 32'(O_ALL));
        step();
        drive(0, 0, 0, 0, 0);
        chk("mem_after_ack", 32'(outs()), 32'(O_ALL));
        step();

        // Ack coinciding with a branch, then with a load-use hazard.
        drive(0, 0, 0, 1, 0);
        chk("mem2_start", 32'(outs()), 32'(O_START));
        step();
        drive(0, 0, 1, 1, 1);
        chk("ack_branch", 32'(outs()), 32'(O_BR));
        step();
        drive(0, 0, 0, 1, 0);
        chk("mem3_start", 32'(outs()), 32'(O_START));
        step();
        drive(0, 1, 0, 1, 1);
        chk("ack_loaduse", 32'(outs()), 32'(O_LU));
        step();

        // Ack on the last permitted wait cycle wins over the timeout.
        drive(0, 0, 0, 1, 0);
        chk("mem4_start", 32'(outs()), 32'(O_START));
        step();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("mem4_wait", 32'(outs()), 32'(O_ZERO));
            step();
        end
        drive(0, 0, 0, 1, 1);
        chk("ack_at_timeout", 32'(outs()), 32'(O_ALL));
        step();
        drive(0, 0, 0, 0, 0);
        chk("run_after_late_edge", 32'(outs()), 32'(O_ALL));
        step();

        // Timeout: eight wait cycles without ack, then HALT.
        drive(0, 0, 0, 1, 0);
        chk("mem5_start", 32'(outs()), 32'(O_START));
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("mem5_wait", 32'(outs()), 32'(O_ZERO));
            step();
        end
        drive(0, 0, 0, 1, 0);
        chk("halt_err", 32'(outs()), 32'(O_HALT));
        step();
        drive(1, 0, 1, 0, 1);
        chk("halt_late_ack", 32'(outs()), 32'(O_HALT));
        step();
        drive(1, 0, 0, 0, 0);
        chk("halt_sticky", 32'(outs()), 32'(O_HALT));
        rst_n = 1'b0;
        #1;
        chk("halt_reset", 32'(outs()), 32'(O_ZERO));
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("idle_after_halt", 32'(outs()), 32'(O_ZERO));
        step();
        drive(1, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0);
        chk("restart_run", 32'(outs()), 32'(O_ALL));
        step();

        // Asynchronous reset in the middle of a memory wait.
        drive(0, 0, 0, 1, 0);
        chk("mem6_start", 32'(outs()), 32'(O_START));
        step();
        drive(0, 0, 0, 1, 1);
        chk("mem6_ack_visible", 32'(outs()), 32'(O_ALL));
        rst_n = 1'b0;
        #1;
        chk("async_reset_wait", 32'(outs()), 32'(O_ZERO));
`ifdef PIPE_PERF_CNT_EN
        chk("async_reset_perf", pc_cyc | pc_mw | pc_lu | pc_fl, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0);
        chk("idle_after_async", 32'(outs()), 32'(O_ZERO));
        step();
        drive(1, 0, 0, 0, 0);
        chk("run_after_async", 32'(outs()), 32'(O_ALL));
        step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
